dma_ddr_bank_sched: RTL and testbench
=====================================

DMA_DDR_BANK_SCHED -- requirements
Module: dma_ddr_bank_sched

Interface
REQ-001 SHALL have parameter NUM_LOCAL_MEM_BANKS, default 4, number of DDR banks behind the bank mux.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 64, per-direction in-flight transaction limit.
REQ-003 SHALL define derived widths: SEL_W = max(1, clog2(NUM_LOCAL_MEM_BANKS)); CNT_W = clog2(MAX_OUTSTANDING+1).
REQ-004 SHALL use one clock, clk; reset is asynchronous and active-high, reset.
REQ-005 SHALL have ports, in this order:
- clk  in  1  clock.
- reset  in  1  async active-high reset.
- req_valid  in  1  new descriptor wants a bank.
- req_bank  in  SEL_W  requested bank index.
- req_ready  out  1  request accepted this cycle.
- ar_fire  in  1  read-address handshake on the selected port.
- r_last_fire  in  1  final read beat handshake.
- aw_fire  in  1  write-address handshake.
- b_fire  in  1  write-response handshake.
- bank_sel  out  SEL_W  registered bank select driven to the bank mux.
- rd_issue_en  out  1  AR issue permitted.
- wr_issue_en  out  1  AW/W issue permitted.
- busy  out  1  state != IDLE.
- err_underflow  out  1  sticky counter-underflow flag.

Function
REQ-006 SHALL implement the FSM states IDLE, ACTIVE, DRAIN and SWITCH.
REQ-007 IDLE: on req_valid, SHALL latch req_bank into bank_sel, pulse req_ready for 1 cycle, and go to ACTIVE on the next cycle.
REQ-008 ACTIVE: req_valid with req_bank == bank_sel SHALL be accepted in the same cycle (req_ready=1) and the FSM SHALL stay in ACTIVE.
REQ-009 ACTIVE: req_valid with req_bank != bank_sel SHALL hold req_ready=0, drop both issue enables in the following cycle, and move to DRAIN.
REQ-010 DRAIN: when rd_cnt==0 and wr_cnt==0, the FSM SHALL go to SWITCH; req_ready SHALL stay 0 in DRAIN.
REQ-011 SWITCH (1 cycle): SHALL load the pending req_bank into bank_sel, assert req_ready, hold both issue enables at 0, and go to ACTIVE.
REQ-012 If req_valid drops during DRAIN, the FSM SHALL still complete the drain and SWITCH to the bank latched on entry to DRAIN.
REQ-013 req_bank >= NUM_LOCAL_MEM_BANKS SHALL be mapped to NUM_LOCAL_MEM_BANKS-1.
REQ-014 rd_cnt SHALL increment on ar_fire and decrement on r_last_fire; a simultaneous increment and decrement SHALL leave it unchanged.
REQ-015 wr_cnt SHALL increment on aw_fire and decrement on b_fire; a simultaneous increment and decrement SHALL leave it unchanged.
REQ-016 rd_issue_en SHALL be 1 only in ACTIVE with rd_cnt < MAX_OUTSTANDING; wr_issue_en SHALL be 1 only in ACTIVE with wr_cnt < MAX_OUTSTANDING. Both are registered, 1-cycle latency from the counter update.
REQ-017 A decrement with the counter at 0 SHALL hold the counter at 0.
REQ-018 An increment with the counter at MAX_OUTSTANDING SHALL hold the counter at MAX_OUTSTANDING.
REQ-019 Counters SHALL track handshakes in every state, including IDLE and DRAIN.
REQ-020 The FSM SHALL return ACTIVE->IDLE only when req_valid=0 and both counters are 0 for 16 consecutive cycles (idle counter, reset on any fire or req_valid).

Reset
REQ-021 While reset=1, and immediately on its assertion with no clock edge required:
- state=IDLE, bank_sel=0, rd_cnt=0, wr_cnt=0, idle counter=0.
- req_ready=0, rd_issue_en=0, wr_issue_en=0, busy=0, err_underflow=0.
REQ-022 Reset asserted mid-DRAIN SHALL discard the pending bank; outstanding counts are lost. Upstream resets the memory port together with this block.

Configuration
REQ-023 Macro DMA_DDR_BANK_SCHED_ERR_CHECK_EN, when defined, SHALL set err_underflow sticky (cleared only by reset) on any decrement at count 0 (REQ-017).
REQ-024 Without DMA_DDR_BANK_SCHED_ERR_CHECK_EN, err_underflow SHALL be tied to 0 and the port list SHALL be unchanged.

Verification
REQ-025 Reset, then req_valid=1 with req_bank=2 in IDLE -> req_ready pulses 1 cycle, bank_sel=2, next cycle rd_issue_en=wr_issue_en=1, busy=1.
REQ-026 ACTIVE at bank 2, 3 ar_fire then req_bank=1 -> issue enables 0; r_last_fire x3 -> SWITCH, bank_sel=1, req_ready=1, ACTIVE next cycle.
REQ-027 MAX_OUTSTANDING=4, 4 aw_fire with no b_fire -> wr_issue_en=0 while rd_issue_en=1; 1 b_fire -> wr_issue_en=1 one cycle later.
REQ-028 ar_fire and r_last_fire in the same cycle at rd_cnt=0 -> rd_cnt stays 0, err_underflow stays 0.
REQ-029 With DMA_DDR_BANK_SCHED_ERR_CHECK_EN defined, b_fire at wr_cnt=0 -> err_underflow=1 and it persists until reset; without the macro -> err_underflow remains 0.
REQ-030 Async reset asserted mid-DRAIN between clock edges -> all outputs 0 immediately; after release, req_bank=3 is accepted from IDLE.

Source files
------------

// File: rtl/dma_ddr_bank_sched.sv
// dma_ddr_bank_sched
// Keeps one DDR bank selected at a time behind the bank mux. A request to a
// different bank stalls new issue, waits until every in-flight read and write
// has drained, then switches bank_sel in a single SWITCH cycle.
// Optional feature: define DMA_DDR_BANK_SCHED_ERR_CHECK_EN to get a sticky
// err_underflow flag on completion handshakes seen with nothing in flight.
// Without it err_underflow is tied to 0.

module dma_ddr_bank_sched #(
  parameter int NUM_LOCAL_MEM_BANKS = 4,
  parameter int MAX_OUTSTANDING     = 64,
  localparam int SEL_W = (NUM_LOCAL_MEM_BANKS > 1) ? $clog2(NUM_LOCAL_MEM_BANKS) : 1,
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [SEL_W-1:0] req_bank,
  output logic             req_ready,
  input  logic             ar_fire,
  input  logic             r_last_fire,
  input  logic             aw_fire,
  input  logic             b_fire,
  output logic [SEL_W-1:0] bank_sel,
  output logic             rd_issue_en,
  output logic             wr_issue_en,
  output logic             busy,
  output logic             err_underflow
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_SWITCH = 2'd3;

  localparam logic [SEL_W-1:0] LAST_BANK = SEL_W'(NUM_LOCAL_MEM_BANKS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  // 16 quiet cycles in ACTIVE (counts 0..15) before falling back to IDLE
  localparam logic [3:0]       IDLE_LAST = 4'd15;

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [SEL_W-1:0] r_bank_sel;
  logic [SEL_W-1:0] r_pend_bank;
  logic [3:0]       r_idle_cnt;
  logic [SEL_W-1:0] w_req_bank_map;
  logic             w_bank_match;
  logic             w_ready;
  logic             w_quiet;
  logic             w_all_zero;

  // Per-direction handshakes: index 0 = read, index 1 = write
  logic [1:0] w_inc_raw;
  logic [1:0] w_dec_raw;
  logic [1:0] w_cnt_zero;
  logic [1:0] w_uflow;
  logic [1:0] w_issue_en;

  assign w_inc_raw = {aw_fire, ar_fire};
  assign w_dec_raw = {b_fire, r_last_fire};

  // Out-of-range bank indices fold onto the highest real bank
  assign w_req_bank_map = (req_bank > LAST_BANK) ? LAST_BANK : req_bank;
  assign w_bank_match   = (w_req_bank_map == r_bank_sel);
  assign w_all_zero     = &w_cnt_zero;
  assign w_quiet        = ~req_valid & ~(|w_inc_raw) & ~(|w_dec_raw) & w_all_zero;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dir
      logic             w_inc;
      logic             w_dec;
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] w_cnt_next;
      logic             r_issue_en;

      // A simultaneous increment and decrement cancel out
      assign w_inc = w_inc_raw[gi] & ~w_dec_raw[gi];
      assign w_dec = w_dec_raw[gi] & ~w_inc_raw[gi];

      assign w_cnt_zero[gi] = (r_cnt == '0);
      assign w_uflow[gi]    = w_dec & (r_cnt == '0);
      assign w_issue_en[gi] = r_issue_en;

      // Saturating next count: clamp at MAX_OUTSTANDING on top, 0 on bottom
      always_comb begin
        w_cnt_next = r_cnt;
        if (w_inc && (r_cnt != CNT_MAX)) begin
          w_cnt_next = r_cnt + CNT_ONE;
        end else if (w_dec && (r_cnt != '0)) begin
          w_cnt_next = r_cnt - CNT_ONE;
        end
      end

      // In-flight counter, tracked in every state
      always_ff @(posedge clk or posedge reset) begin
        if (reset) r_cnt <= '0;
        else       r_cnt <= w_cnt_next;
      end

      // Issue enable looks at the state and count being entered so that
      // it drops on the same edge the FSM leaves ACTIVE or the limit is hit
      always_ff @(posedge clk or posedge reset) begin
        if (reset) r_issue_en <= 1'b0;
        else       r_issue_en <= (w_state_next == ST_ACTIVE) && (w_cnt_next < CNT_MAX);
      end
    end
  endgenerate

  // Next-state and request-acceptance decode
  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_ready      = 1'b1;
          w_state_next = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (req_valid) begin
          if (w_bank_match) w_ready      = 1'b1;
          else              w_state_next = ST_DRAIN;
        end else if (w_quiet && (r_idle_cnt == IDLE_LAST)) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (w_all_zero) w_state_next = ST_SWITCH;
      end
      ST_SWITCH: begin
        // Acknowledges the request that caused the drain
        w_ready      = 1'b1;
        w_state_next = ST_ACTIVE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Consecutive quiet cycles spent in ACTIVE; any activity restarts the run
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idle_cnt <= 4'd0;
    end else if ((r_state == ST_ACTIVE) && w_quiet && (w_state_next == ST_ACTIVE)) begin
      r_idle_cnt <= r_idle_cnt + 4'd1;
    end else begin
      r_idle_cnt <= 4'd0;
    end
  end

  // Bank that will be selected once the current bank has drained
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend_bank <= '0;
    end else if ((r_state == ST_ACTIVE) && req_valid && !w_bank_match) begin
      r_pend_bank <= w_req_bank_map;
    end
  end

  // Bank select: taken from the request in IDLE, from the pending bank on
  // entry to SWITCH so it is already valid while SWITCH acknowledges
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bank_sel <= '0;
    end else if ((r_state == ST_IDLE) && req_valid) begin
      r_bank_sel <= w_req_bank_map;
    end else if ((r_state == ST_DRAIN) && (w_state_next == ST_SWITCH)) begin
      r_bank_sel <= r_pend_bank;
    end
  end

`ifdef DMA_DDR_BANK_SCHED_ERR_CHECK_EN
  logic r_err_underflow;

  // Sticky record of any completion seen with nothing outstanding
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_err_underflow <= 1'b0;
    else       r_err_underflow <= r_err_underflow | (|w_uflow);
  end

  assign err_underflow = r_err_underflow;
`else
  logic [1:0] w_uflow_unused;
  assign w_uflow_unused = w_uflow;
  assign err_underflow  = 1'b0;
`endif

  // Ready is masked by reset so it is low the instant reset rises
  assign req_ready   = w_ready & ~reset;
  assign bank_sel    = r_bank_sel;
  assign rd_issue_en = w_issue_en[0];
  assign wr_issue_en = w_issue_en[1];
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dma_ddr_bank_sched.sv
// Bench for dma_ddr_bank_sched: directed scenarios plus a randomized run
// compared cycle by cycle with a behavioural model of the scheduler.
// Built with NUM_LOCAL_MEM_BANKS=6 (so indices 6,7 fold onto bank 5) and
// MAX_OUTSTANDING=4 (so the issue limit is reached quickly).
// Honours DMA_DDR_BANK_SCHED_ERR_CHECK_EN for the err_underflow expectation.

module tb_dma_ddr_bank_sched;

  localparam int NB = 6;
  localparam int MO = 4;
  localparam int SW = 3;

`ifdef DMA_DDR_BANK_SCHED_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk         = 1'b0;
  logic          reset       = 1'b0;
  logic          req_valid   = 1'b0;
  logic [SW-1:0] req_bank    = '0;
  logic          ar_fire     = 1'b0;
  logic          r_last_fire = 1'b0;
  logic          aw_fire     = 1'b0;
  logic          b_fire      = 1'b0;
  logic          req_ready;
  logic [SW-1:0] bank_sel;
  logic          rd_issue_en;
  logic          wr_issue_en;
  logic          busy;
  logic          err_underflow;

  int total = 0;
  int bad   = 0;

  dma_ddr_bank_sched #(
    .NUM_LOCAL_MEM_BANKS(NB),
    .MAX_OUTSTANDING    (MO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_bank     (req_bank),
    .req_ready    (req_ready),
    .ar_fire      (ar_fire),
    .r_last_fire  (r_last_fire),
    .aw_fire      (aw_fire),
    .b_fire       (b_fire),
    .bank_sel     (bank_sel),
    .rd_issue_en  (rd_issue_en),
    .wr_issue_en  (wr_issue_en),
    .busy         (busy),
    .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef enum int {MI, MA, MD, MS} phase_t;
  phase_t m_phase = MI;
  int     m_bank  = 0;
  int     m_pend  = 0;
  int     m_rd    = 0;
  int     m_wr    = 0;
  int     m_quiet = 0;
  bit     m_err   = 1'b0;
  bit     m_rd_en = 1'b0;
  bit     m_wr_en = 1'b0;

  function automatic int map_bank(int b);
    return (b >= NB) ? NB - 1 : b;
  endfunction

  function automatic bit exp_ready();
    case (m_phase)
      MI:      return req_valid;
      MA:      return req_valid && (map_bank(int'(req_bank)) == m_bank);
      MD:      return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = MI; m_bank = 0; m_pend = 0; m_rd = 0; m_wr = 0;
    m_quiet = 0; m_err = 1'b0; m_rd_en = 1'b0; m_wr_en = 1'b0;
  endtask

  task automatic model_advance();
    int nrd;
    int nwr;
    int mb;
    bit quiet;
    nrd = m_rd + int'(ar_fire) - int'(r_last_fire);
    nwr = m_wr + int'(aw_fire) - int'(b_fire);
    if ((nrd < 0) || (nwr < 0)) m_err = m_err | ERR_EN;
    nrd = (nrd < 0) ? 0 : ((nrd > MO) ? MO : nrd);
    nwr = (nwr < 0) ? 0 : ((nwr > MO) ? MO : nwr);
    quiet = !req_valid && !ar_fire && !r_last_fire && !aw_fire && !b_fire &&
            (m_rd == 0) && (m_wr == 0);
    mb = map_bank(int'(req_bank));
    case (m_phase)
      MI: begin
        m_quiet = 0;
        if (req_valid) begin m_bank = mb; m_phase = MA; end
      end
      MA: begin
        if (req_valid) begin
          m_quiet = 0;
          if (mb != m_bank) begin m_pend = mb; m_phase = MD; end
        end else if (quiet) begin
          m_quiet++;
          if (m_quiet == 16) begin m_quiet = 0; m_phase = MI; end
        end else begin
          m_quiet = 0;
        end
      end
      MD: begin
        m_quiet = 0;
        if ((m_rd == 0) && (m_wr == 0)) begin m_bank = m_pend; m_phase = MS; end
      end
      default: begin
        m_quiet = 0;
        m_phase = MA;
      end
    endcase
    m_rd    = nrd;
    m_wr    = nwr;
    m_rd_en = (m_phase == MA) && (m_rd < MO);
    m_wr_en = (m_phase == MA) && (m_wr < MO);
  endtask

  // Advance model and DUT by one clock; returns at posedge + 1
  task automatic tick();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_valid = 1'b0; req_bank = '0;
    ar_fire = 1'b0; r_last_fire = 1'b0; aw_fire = 1'b0; b_fire = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2;
    req_valid = 1'b1; req_bank = 3'd3; ar_fire = 1'b1; aw_fire = 1'b1;
    reset = 1'b1;
    #1;
    total++; if (req_ready !== 1'b0)   begin bad++; $display("FAIL rst_ready: got %0b want 0", req_ready); end
    total++; if (bank_sel !== 3'd0)    begin bad++; $display("FAIL rst_bank_sel: got %0d want 0", bank_sel); end
    total++; if (rd_issue_en !== 1'b0) begin bad++; $display("FAIL rst_rd_en: got %0b want 0", rd_issue_en); end
    total++; if (wr_issue_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en: got %0b want 0", wr_issue_en); end
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
    total++; if (err_underflow !== 1'b0) begin bad++; $display("FAIL rst_err: got %0b want 0", err_underflow); end
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_hold_busy: got %0b want 0", busy); end
    apply_reset();
    $display("test_reset done");
  endtask

  task automatic test_accept();
    apply_reset();
    req_valid = 1'b1; req_bank = 3'd2;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL acc_ready: got %0b want 1", req_ready); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL acc_busy_idle: got %0b want 0", busy); end
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    total++; if (req_ready !== 1'b0)   begin bad++; $display("FAIL acc_ready_pulse: got %0b want 0", req_ready); end
    total++; if (bank_sel !== 3'd2)    begin bad++; $display("FAIL acc_bank_sel: got %0d want 2", bank_sel); end
    total++; if (rd_issue_en !== 1'b1) begin bad++; $display("FAIL acc_rd_en: got %0b want 1", rd_issue_en); end
    total++; if (wr_issue_en !== 1'b1) begin bad++; $display("FAIL acc_wr_en: got %0b want 1", wr_issue_en); end
    total++; if (busy !== 1'b1)        begin bad++; $display("FAIL acc_busy: got %0b want 1", busy); end
    $display("test_accept done");
  endtask

  // Runs straight after test_accept: ACTIVE on bank 2, nothing in flight
  task automatic test_bank_switch();
    ar_fire = 1'b1;
    repeat (3) tick();
    ar_fire = 1'b0; req_valid = 1'b1; req_bank = 3'd1;
    @(negedge clk);
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL sw_ready_mismatch: got %0b want 0", req_ready); end
    tick();
    r_last_fire = 1'b1;
    @(negedge clk);
    total++; if (rd_issue_en !== 1'b0) begin bad++; $display("FAIL sw_drain_rd_en: got %0b want 0", rd_issue_en); end
    total++; if (wr_issue_en !== 1'b0) begin bad++; $display("FAIL sw_drain_wr_en: got %0b want 0", wr_issue_en); end
    total++; if (req_ready !== 1'b0)   begin bad++; $display("FAIL sw_drain_ready: got %0b want 0", req_ready); end
    repeat (3) tick();
    r_last_fire = 1'b0;
    @(negedge clk);
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL sw_drain_last_ready: got %0b want 0", req_ready); end
    total++; if (bank_sel !== 3'd2)  begin bad++; $display("FAIL sw_drain_bank: got %0d want 2", bank_sel); end
    tick();
    @(negedge clk);
    total++; if (bank_sel !== 3'd1)    begin bad++; $display("FAIL sw_switch_bank: got %0d want 1", bank_sel); end
    total++; if (req_ready !== 1'b1)   begin bad++; $display("FAIL sw_switch_ready: got %0b want 1", req_ready); end
    total++; if (rd_issue_en !== 1'b0) begin bad++; $display("FAIL sw_switch_rd_en: got %0b want 0", rd_issue_en); end
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    total++; if (rd_issue_en !== 1'b1) begin bad++; $display("FAIL sw_active_rd_en: got %0b want 1", rd_issue_en); end
    total++; if (busy !== 1'b1)        begin bad++; $display("FAIL sw_active_busy: got %0b want 1", busy); end
    $display("test_bank_switch done");
  endtask

  // Runs straight after test_bank_switch: ACTIVE on bank 1, nothing in flight
  task automatic test_drain_drop();
    aw_fire = 1'b1;
    tick();
    aw_fire = 1'b0; req_valid = 1'b1; req_bank = 3'd3;
    @(negedge clk);
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL dd_ready: got %0b want 0", req_ready); end
    tick();
    req_valid = 1'b0; req_bank = 3'd0; b_fire = 1'b1;
    @(negedge clk);
    total++; if (wr_issue_en !== 1'b0) begin bad++; $display("FAIL dd_wr_en: got %0b want 0", wr_issue_en); end
    tick();
    b_fire = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL dd_busy: got %0b want 1", busy); end
    tick();
    @(negedge clk);
    total++; if (bank_sel !== 3'd3)  begin bad++; $display("FAIL dd_switch_bank: got %0d want 3", bank_sel); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL dd_switch_ready: got %0b want 1", req_ready); end
    tick();
    @(negedge clk);
    total++; if (wr_issue_en !== 1'b1) begin bad++; $display("FAIL dd_active_wr_en: got %0b want 1", wr_issue_en); end
    $display("test_drain_drop done");
  endtask

  task automatic test_bank_map();
    apply_reset();
    req_valid = 1'b1; req_bank = 3'd7;
    tick();
    req_bank = 3'd6;
    @(negedge clk);
    total++; if (bank_sel !== 3'd5)  begin bad++; $display("FAIL map_bank_sel: got %0d want 5", bank_sel); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL map_same_bank_ready: got %0b want 1", req_ready); end
    tick();
    req_valid = 1'b0;
    $display("test_bank_map done");
  endtask

  // Runs straight after test_bank_map: ACTIVE on bank 5, nothing in flight
  task automatic test_idle_return();
    repeat (5) tick();
    req_valid = 1'b1; req_bank = 3'd5;
    tick();
    req_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL idle_hold_%0d: busy got %0b want 1", k, busy); end
      tick();
    end
    @(negedge clk);
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL idle_return_busy: got %0b want 0", busy); end
    total++; if (rd_issue_en !== 1'b0) begin bad++; $display("FAIL idle_return_rd_en: got %0b want 0", rd_issue_en); end
    $display("test_idle_return done");
  endtask

  task automatic test_outstanding();
    apply_reset();
    req_valid = 1'b1; req_bank = 3'd0;
    tick();
    req_valid = 1'b0; aw_fire = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      @(negedge clk);
      total++; if (wr_issue_en !== (i < MO)) begin bad++; $display("FAIL out_wr_en_%0d: got %0b want %0b", i, wr_issue_en, (i < MO)); end
      total++; if (rd_issue_en !== 1'b1)     begin bad++; $display("FAIL out_rd_en_%0d: got %0b want 1", i, rd_issue_en); end
    end
    aw_fire = 1'b0; b_fire = 1'b1;
    tick();
    @(negedge clk);
    total++; if (wr_issue_en !== 1'b1) begin bad++; $display("FAIL out_after_b: got %0b want 1", wr_issue_en); end
    aw_fire = 1'b1; b_fire = 1'b1;
    tick();
    @(negedge clk);
    total++; if (wr_issue_en !== 1'b1) begin bad++; $display("FAIL out_both_fire: got %0b want 1", wr_issue_en); end
    b_fire = 1'b0;
    tick();
    @(negedge clk);
    total++; if (wr_issue_en !== 1'b0) begin bad++; $display("FAIL out_refill: got %0b want 0", wr_issue_en); end
    aw_fire = 1'b0;
    $display("test_outstanding done");
  endtask

  task automatic test_same_cycle();
    apply_reset();
    ar_fire = 1'b1; r_last_fire = 1'b1;
    tick();
    ar_fire = 1'b0; r_last_fire = 1'b0;
    @(negedge clk);
    total++; if (err_underflow !== 1'b0) begin bad++; $display("FAIL same_err: got %0b want 0", err_underflow); end
    req_valid = 1'b1; req_bank = 3'd0;
    tick();
    req_valid = 1'b0; ar_fire = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      @(negedge clk);
      total++; if (rd_issue_en !== (i < MO)) begin bad++; $display("FAIL same_rd_en_%0d: got %0b want %0b", i, rd_issue_en, (i < MO)); end
    end
    ar_fire = 1'b0;
    $display("test_same_cycle done");
  endtask

  task automatic test_underflow();
    apply_reset();
    b_fire = 1'b1;
    tick();
    b_fire = 1'b0;
    @(negedge clk);
    total++; if (err_underflow !== ERR_EN) begin bad++; $display("FAIL uf_set: got %0b want %0b", err_underflow, ERR_EN); end
    aw_fire = 1'b1;
    repeat (3) tick();
    aw_fire = 1'b0;
    @(negedge clk);
    total++; if (err_underflow !== ERR_EN) begin bad++; $display("FAIL uf_sticky: got %0b want %0b", err_underflow, ERR_EN); end
    apply_reset();
    @(negedge clk);
    total++; if (err_underflow !== 1'b0) begin bad++; $display("FAIL uf_cleared: got %0b want 0", err_underflow); end
    $display("test_underflow done");
  endtask

  task automatic test_reset_mid_drain();
    apply_reset();
    req_valid = 1'b1; req_bank = 3'd2;
    tick();
    req_valid = 1'b0; ar_fire = 1'b1; aw_fire = 1'b1;
    repeat (2) tick();
    ar_fire = 1'b0; aw_fire = 1'b0; req_valid = 1'b1; req_bank = 3'd0;
    tick();
    #2;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_drain_busy: got %0b want 1", busy); end
    reset = 1'b1;
    #1;
    total++; if (req_ready !== 1'b0)   begin bad++; $display("FAIL mid_rst_ready: got %0b want 0", req_ready); end
    total++; if (bank_sel !== 3'd0)    begin bad++; $display("FAIL mid_rst_bank_sel: got %0d want 0", bank_sel); end
    total++; if (rd_issue_en !== 1'b0) begin bad++; $display("FAIL mid_rst_rd_en: got %0b want 0", rd_issue_en); end
    total++; if (wr_issue_en !== 1'b0) begin bad++; $display("FAIL mid_rst_wr_en: got %0b want 0", wr_issue_en); end
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL mid_rst_busy: got %0b want 0", busy); end
    total++; if (err_underflow !== 1'b0) begin bad++; $display("FAIL mid_rst_err: got %0b want 0", err_underflow); end
    clear_inputs();
    model_reset();
    @(posedge clk); #3;
    reset = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_bank = 3'd3;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready: got %0b want 1", req_ready); end
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    total++; if (bank_sel !== 3'd3)    begin bad++; $display("FAIL post_rst_bank: got %0d want 3", bank_sel); end
    total++; if (rd_issue_en !== 1'b1) begin bad++; $display("FAIL post_rst_rd_en: got %0b want 1", rd_issue_en); end
    $display("test_reset_mid_drain done");
  endtask

  task automatic test_random();
    logic [SW+4:0] a_vec;
    logic [SW+4:0] e_vec;
    apply_reset();
    for (int c = 0; c < 500; c++) begin
      req_valid   = ($urandom_range(0, 99) < 40);
      req_bank    = SW'($urandom_range(0, 7));
      ar_fire     = ($urandom_range(0, 99) < 30);
      r_last_fire = ($urandom_range(0, 99) < 30);
      aw_fire     = ($urandom_range(0, 99) < 30);
      b_fire      = ($urandom_range(0, 99) < 30);
      @(negedge clk);
      a_vec = {req_ready, bank_sel, rd_issue_en, wr_issue_en, busy, err_underflow};
      e_vec = {exp_ready(), SW'(m_bank), m_rd_en, m_wr_en, (m_phase != MI), m_err};
      total++;
      if (a_vec !== e_vec) begin
        bad++;
        $display("FAIL rand_cycle_%0d {ready,bank,rd_en,wr_en,busy,err}: got %b want %b", c, a_vec, e_vec);
      end
      tick();
    end
    clear_inputs();
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_accept();
    test_bank_switch();
    test_drain_drop();
    test_bank_map();
    test_idle_return();
    test_outstanding();
    test_same_cycle();
    test_underflow();
    test_reset_mid_drain();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
